deck_stream: RTL and testbench
==============================

DECK_STREAM -- requirements
Module: deck_stream

Interface
REQ-001 Parameter DEPTH, default 32: total card capacity across draw and discard piles, power of two, max 32.
REQ-002 Parameter COPPER_ID, default 1: 4-bit card id loaded 7 times at game start.
REQ-003 Parameter ESTATE_ID, default 4: 4-bit card id loaded 3 times at game start.
REQ-004 Parameter LFSR_SEED, default 16'hACE1: shuffle LFSR reset value, nonzero.
REQ-005 clk  in  1  single clock; all state changes on rising edge.
REQ-006 reset  in  1  asynchronous, active-low; low clears all state immediately.
REQ-007 mode  in  3  game phase: START=1, ACTION=2, ACTIONEND=3, BUY=4, DRAW=5, ENDGAME=6.
REQ-008 nextcard  in  1  consume request from downstream decoder.
REQ-009 gain_valid  in  1  one-cycle strobe: add gain_card to the discard pile.
REQ-010 gain_card  in  4  id of gained card.
REQ-011 card_stream  out  4  id of the top draw-pile card.
REQ-012 card_valid  out  1  card_stream holds a consumable card.
REQ-013 draw_count  out  6  cards in draw pile.
REQ-014 discard_count  out  6  cards in discard pile.
REQ-015 busy  out  1  load or shuffle in progress.
REQ-016 overflow  out  1  sticky: a gain was dropped.

Function
REQ-017 States SHALL be IDLE, LOAD, COPY, SWAP, READY.
REQ-018 IDLE SHALL move to LOAD when mode==START; card_valid=0 in IDLE.
REQ-019 LOAD SHALL write one card per cycle into discard: 7 x COPPER_ID then 3 x ESTATE_ID (10 cycles), then enter COPY.
REQ-020 COPY SHALL move discard[i] to draw[i] one card per cycle in index order, i from 0; on completion draw_count=old discard_count, discard_count=0; then SWAP.
REQ-021 SWAP SHALL run i from draw_count-1 down to 1, one step per cycle: r=LFSR[4:0]; j=r if r<=i, else r-i-1 if that <=i, else i; swap draw[i] and draw[j]; advance LFSR once per step; then READY.
REQ-022 LFSR SHALL be 16-bit Fibonacci, taps 16,14,13,11, shifting left with feedback in bit 0, advancing only in SWAP.
REQ-023 busy SHALL be 1 exactly in LOAD, COPY, SWAP.
REQ-024 In READY, card_stream SHALL be combinationally draw[draw_count-1]; card_valid=(draw_count!=0).
REQ-025 nextcard high at an edge with card_valid=1 SHALL pop the top card and push it onto discard in the same edge; back-to-back consumption every cycle SHALL be supported.
REQ-026 nextcard with card_valid=0 SHALL be ignored.
REQ-027 In READY, draw_count==0 and discard_count!=0 and mode!=ENDGAME SHALL enter COPY on the next edge.
REQ-028 In ENDGAME, consumed cards SHALL NOT be pushed to discard and no reshuffle SHALL occur; when draw empties, discard SHALL be streamed top-down in place of the draw pile, then card_valid=0.
REQ-029 gain_valid SHALL be accepted in any state except LOAD, appending to discard top; in COPY the append SHALL be deferred until COPY completes (single-entry hold register).
REQ-030 Gain when draw_count+discard_count==DEPTH SHALL be dropped and set overflow; a second gain while the hold register is full SHALL also be dropped and set overflow.
REQ-031 Gain and consume in the same READY edge SHALL both apply; discard_count increases by 2.
REQ-032 mode==START outside IDLE SHALL be ignored.

Reset
REQ-033 Reset low SHALL give: state IDLE, counts 0, card_valid 0, card_stream 0, busy 0, overflow 0, LFSR=LFSR_SEED, hold register empty; reset mid-shuffle SHALL discard partial results.

Configuration
REQ-034 Macro DECK_SHUFFLE_EN: defined -> SWAP performed as REQ-021; undefined -> COPY proceeds directly to READY, draw order equals discard order, LFSR absent.

Verification
REQ-035 Reset, mode=START -> busy for 10 LOAD + 10 COPY (+9 SWAP if enabled) cycles, then draw_count=10, discard_count=0, card_valid=1.
REQ-036 Without DECK_SHUFFLE_EN, after load, 10 consecutive nextcard -> card_stream 4,4,4,1,1,1,1,1,1,1; then draw_count=0, discard_count=10, reshuffle starts next cycle.
REQ-037 With DECK_SHUFFLE_EN, two runs with seed ACE1 -> identical 10-card sequence matching reference model, containing exactly seven 1s and three 4s.
REQ-038 Fill to 32 cards via gain_valid, one more gain (id 11) -> counts unchanged, overflow=1 until reset.
REQ-039 mode=ENDGAME with draw=2, discard=3 -> exactly 5 cards streamed, then card_valid=0, discard_count=0, busy never asserts.
REQ-040 Reset asserted mid-SWAP -> all outputs zero within same cycle; restart with START reproduces REQ-035 sequence.

Source files
------------

// File: rtl/deck_stream.sv
// Card deck manager: loads the starter deck, moves discard into draw, streams the top draw card.
// Define DECK_SHUFFLE_EN to add the LFSR-driven shuffle pass (SWAP) after every copy.
module deck_stream #(
    parameter int          DEPTH     = 32,
    parameter logic [3:0]  COPPER_ID = 4'd1,
    parameter logic [3:0]  ESTATE_ID = 4'd4,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] mode,
    input  logic       nextcard,
    input  logic       gain_valid,
    input  logic [3:0] gain_card,
    output logic [3:0] card_stream,
    output logic       card_valid,
    output logic [5:0] draw_count,
    output logic [5:0] discard_count,
    output logic       busy,
    output logic       overflow
);

    localparam int         AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [5:0] CAP       = 6'(DEPTH);
    localparam logic [2:0] M_START   = 3'd1;
    localparam logic [2:0] M_ENDGAME = 3'd6;

    typedef enum logic [2:0] {IDLE, LOAD, COPY, SWAP, READY} state_t;
    state_t state, state_nxt;

    logic [3:0] draw_mem [DEPTH];
    logic [3:0] disc_mem [DEPTH];
    logic [5:0] step;       // LOAD card number, COPY index, SWAP index i
    logic       hold_v;
    logic [3:0] hold_card;

    logic [5:0] draw_top, disc_top, total, gain_pos;
    logic       endgame, consume, pop_draw, pop_disc, push_used;
    logic       gain_ok, gain_drop, copy_done;

`ifdef DECK_SHUFFLE_EN
    logic [15:0] lfsr;
    logic [5:0]  swap_r, swap_j;

    always_comb begin
        swap_r = {1'b0, lfsr[4:0]};
        if (swap_r <= step)
            swap_j = swap_r;
        else if (swap_r - step - 6'd1 <= step)
            swap_j = swap_r - step - 6'd1;
        else
            swap_j = step;
    end
`endif

    assign draw_top  = draw_count - 6'd1;
    assign disc_top  = discard_count - 6'd1;
    assign total     = draw_count + discard_count + {5'd0, hold_v};
    assign endgame   = (mode == M_ENDGAME);
    assign copy_done = (state == COPY) && (discard_count == 6'd0 || step == disc_top);
    assign busy      = (state == LOAD) || (state == COPY) || (state == SWAP);

    // In ENDGAME the discard pile takes over once the draw pile runs dry.
    always_comb begin
        card_valid  = 1'b0;
        card_stream = 4'd0;
        if (state == READY) begin
            if (draw_count != 6'd0) begin
                card_valid  = 1'b1;
                card_stream = draw_mem[draw_top[AW-1:0]];
            end else if (endgame && discard_count != 6'd0) begin
                card_valid  = 1'b1;
                card_stream = disc_mem[disc_top[AW-1:0]];
            end
        end
    end

    assign consume   = card_valid && nextcard;
    assign pop_draw  = consume && (draw_count != 6'd0);
    assign pop_disc  = consume && (draw_count == 6'd0);
    assign push_used = pop_draw && !endgame;
    assign gain_ok   = gain_valid && (state != LOAD) && (total < CAP) && !((state == COPY) && hold_v);
    assign gain_drop = gain_valid && (state != LOAD) && !gain_ok;
    // A consumed card lands on discard first, a same-edge gain goes above it.
    assign gain_pos  = discard_count + {5'd0, push_used} - {5'd0, pop_disc};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (mode == M_START) state_nxt = LOAD;
            LOAD:  if (step == 6'd9) state_nxt = COPY;
            COPY:  if (copy_done) begin
`ifdef DECK_SHUFFLE_EN
                       state_nxt = (discard_count > 6'd1) ? SWAP : READY;
`else
                       state_nxt = READY;
`endif
                   end
            SWAP:  if (step <= 6'd1) state_nxt = READY;
            READY: if (draw_count == 6'd0 && discard_count != 6'd0 && !endgame) state_nxt = COPY;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            draw_count    <= 6'd0;
            discard_count <= 6'd0;
            step          <= 6'd0;
            hold_v        <= 1'b0;
            hold_card     <= 4'd0;
            overflow      <= 1'b0;
`ifdef DECK_SHUFFLE_EN
            lfsr          <= LFSR_SEED;
`endif
            for (int k = 0; k < DEPTH; k++) begin
                draw_mem[k] <= 4'd0;
                disc_mem[k] <= 4'd0;
            end
        end else begin
            if (gain_drop) overflow <= 1'b1;
            case (state)
                LOAD: begin
                    if (total < CAP) begin
                        disc_mem[discard_count[AW-1:0]] <= (step < 6'd7) ? COPPER_ID : ESTATE_ID;
                        discard_count <= discard_count + 6'd1;
                    end
                    step <= (step == 6'd9) ? 6'd0 : step + 6'd1;
                end
                COPY: begin
                    if (discard_count != 6'd0)
                        draw_mem[step[AW-1:0]] <= disc_mem[step[AW-1:0]];
                    if (copy_done) begin
                        // step already equals the new draw top, i.e. the first SWAP index
                        draw_count <= discard_count;
                        hold_v     <= 1'b0;
                        if (hold_v) begin
                            disc_mem[0]   <= hold_card;
                            discard_count <= 6'd1;
                        end else if (gain_ok) begin
                            disc_mem[0]   <= gain_card;
                            discard_count <= 6'd1;
                        end else begin
                            discard_count <= 6'd0;
                        end
                    end else begin
                        step <= step + 6'd1;
                        if (gain_ok) begin
                            hold_v    <= 1'b1;
                            hold_card <= gain_card;
                        end
                    end
                end
                default: begin
                    if (push_used) disc_mem[discard_count[AW-1:0]] <= card_stream;
                    if (gain_ok)   disc_mem[gain_pos[AW-1:0]] <= gain_card;
                    discard_count <= discard_count + {5'd0, push_used} + {5'd0, gain_ok} - {5'd0, pop_disc};
                    if (pop_draw) draw_count <= draw_count - 6'd1;
                    step <= 6'd0;
`ifdef DECK_SHUFFLE_EN
                    if (state == SWAP) begin
                        draw_mem[step[AW-1:0]]   <= draw_mem[swap_j[AW-1:0]];
                        draw_mem[swap_j[AW-1:0]] <= draw_mem[step[AW-1:0]];
                        step <= step - 6'd1;
                        lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
                    end
`endif
                end
            endcase
        end
    end

endmodule

// File: tb/tb_deck_stream.sv
// Scoreboard bench for deck_stream: expected cards are queued at issue, a negedge monitor checks them.
// Builds against either configuration of DECK_SHUFFLE_EN.
module tb_deck_stream;

    localparam logic [2:0] M_START   = 3'd1;
    localparam logic [2:0] M_ACTION  = 3'd2;
    localparam logic [2:0] M_ENDGAME = 3'd6;
`ifdef DECK_SHUFFLE_EN
    localparam int BUSY_EXP = 29;
    localparam int RST_WAIT = 12;
`else
    localparam int BUSY_EXP = 20;
    localparam int RST_WAIT = 3;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] mode;
    logic       nextcard, gain_valid;
    logic [3:0] gain_card, card_stream;
    logic       card_valid, busy, overflow;
    logic [5:0] draw_count, discard_count;

    always #5 clk = ~clk;

    deck_stream dut (
        .clk(clk), .reset(reset), .mode(mode), .nextcard(nextcard),
        .gain_valid(gain_valid), .gain_card(gain_card), .card_stream(card_stream),
        .card_valid(card_valid), .draw_count(draw_count), .discard_count(discard_count),
        .busy(busy), .overflow(overflow)
    );

    int         tests = 0;
    int         fails = 0;
    logic [3:0] q[$];
    int         d[10];      // draw pile order after the initial load, index 9 = top
    logic       watch_busy = 1'b0;
    logic       busy_seen  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_card_stream"}, card_stream, 0);
        check({tag, "_card_valid"}, card_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_draw_count"}, draw_count, 0);
        check({tag, "_discard_count"}, discard_count, 0);
        check({tag, "_overflow"}, overflow, 0);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b0; mode = 3'd0; nextcard = 1'b0; gain_valid = 1'b0;
        #1;
        check_zero(tag);
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic start_game(input int g1, input int g2, output int ncyc);
        mode = M_START;
        tick();
        mode = M_ACTION;
        ncyc = 0;
        while (busy && ncyc < 200) begin
            gain_valid = (ncyc == g1 || ncyc == g2);
            gain_card  = (ncyc == g2) ? 4'd8 : 4'd7;
            ncyc++;
            tick();
        end
        gain_valid = 1'b0;
    endtask

    task automatic gain(input logic [3:0] id);
        gain_valid = 1'b1;
        gain_card  = id;
        tick();
        gain_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (watch_busy && busy) busy_seen = 1'b1;
        if (reset && nextcard && card_valid) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL stream_extra: got card %0d, expected no card", card_stream);
            end else begin
                check("stream", card_stream, q.pop_front());
            end
        end
    end

    initial begin
        int n;
        int exp5[5];
        int exp12[12];
`ifdef DECK_SHUFFLE_EN
        logic [15:0] l;
        int r, j, t;
        d = '{1, 1, 1, 1, 1, 1, 1, 4, 4, 4};
        l = 16'hACE1;
        for (int i = 9; i >= 1; i--) begin
            r = int'(l[4:0]);
            if (r <= i) j = r;
            else if (r - i - 1 <= i) j = r - i - 1;
            else j = i;
            t = d[i]; d[i] = d[j]; d[j] = t;
            l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
        end
`else
        d = '{1, 1, 1, 1, 1, 1, 1, 4, 4, 4};
`endif
        reset = 1'b0; mode = 3'd0; nextcard = 1'b0; gain_valid = 1'b0; gain_card = 4'd0;
        #1;
        check_zero("por");
        tick();
        reset = 1'b1;
        tick();

        // consume request with nothing valid must not move anything
        nextcard = 1'b1;
        tick();
        tick();
        nextcard = 1'b0;
        check("idle_nextcard_draw", draw_count, 0);
        check("idle_nextcard_discard", discard_count, 0);

        // run A: load, drain ten cards, reshuffle starts, reset mid-shuffle
        start_game(-1, -1, n);
        check("load_busy_cycles", n, BUSY_EXP);
        check("load_draw_count", draw_count, 10);
        check("load_discard_count", discard_count, 0);
        check("load_card_valid", card_valid, 1);
        for (int k = 0; k < 10; k++) begin
            q.push_back(4'(d[9-k]));
            nextcard = 1'b1;
            tick();
        end
        nextcard = 1'b0;
        check("drain_draw_count", draw_count, 0);
        check("drain_discard_count", discard_count, 10);
        check("drain_card_valid", card_valid, 0);
        check("drain_busy", busy, 0);
        tick();
        check("reshuffle_started", busy, 1);
        repeat (RST_WAIT) tick();
        #2;
        do_reset("mid_shuffle_reset");

        // run B: restart, then ENDGAME with draw=2 / discard=3, then capacity fill
        start_game(-1, -1, n);
        check("restart_busy_cycles", n, BUSY_EXP);
        check("restart_draw_count", draw_count, 10);
        check("restart_card_valid", card_valid, 1);
        mode = M_ENDGAME;
        watch_busy = 1'b1;
        for (int k = 0; k < 8; k++) begin
            q.push_back(4'(d[9-k]));
            nextcard = 1'b1;
            tick();
        end
        nextcard = 1'b0;
        check("endgame_draw_count", draw_count, 2);
        check("endgame_no_push", discard_count, 0);
        gain(4'd11);
        gain(4'd12);
        gain(4'd13);
        check("endgame_gain_count", discard_count, 3);
        exp5 = '{d[1], d[0], 13, 12, 11};
        n = 0;
        nextcard = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (!card_valid) break;
            if (n < 5) q.push_back(4'(exp5[n]));
            n++;
            tick();
        end
        nextcard = 1'b0;
        check("endgame_streamed", n, 5);
        check("endgame_valid_off", card_valid, 0);
        check("endgame_discard_empty", discard_count, 0);
        check("endgame_never_busy", busy_seen, 0);
        watch_busy = 1'b0;

        for (int i = 0; i < 32; i++) begin
            gain_valid = 1'b1;
            gain_card  = 4'(i);
            tick();
        end
        gain_valid = 1'b0;
        check("fill_discard_count", discard_count, 32);
        check("fill_overflow", overflow, 0);
        gain(4'd11);
        check("full_gain_discard", discard_count, 32);
        check("full_gain_draw", draw_count, 0);
        check("full_gain_overflow", overflow, 1);
        repeat (3) tick();
        check("overflow_sticky", overflow, 1);
        do_reset("reset_clears_overflow");

        // run C: gains during COPY use the hold register, then gain + consume on one edge
        start_game(12, 13, n);
        check("hold_busy_cycles", n, BUSY_EXP);
        check("hold_draw_count", draw_count, 10);
        check("hold_flush", discard_count, 1);
        check("hold_full_drop", overflow, 1);
        q.push_back(4'(d[9]));
        nextcard   = 1'b1;
        gain_valid = 1'b1;
        gain_card  = 4'd9;
        tick();
        nextcard   = 1'b0;
        gain_valid = 1'b0;
        check("dual_draw_count", draw_count, 9);
        check("dual_discard_count", discard_count, 3);
        mode = M_ENDGAME;
        for (int k = 0; k < 9; k++) exp12[k] = d[8-k];
        exp12[9]  = 9;
        exp12[10] = d[9];
        exp12[11] = 7;
        n = 0;
        nextcard = 1'b1;
        for (int k = 0; k < 30; k++) begin
            if (!card_valid) break;
            if (n < 12) q.push_back(4'(exp12[n]));
            n++;
            tick();
        end
        nextcard = 1'b0;
        check("dual_drain_count", n, 12);
        check("dual_drain_valid_off", card_valid, 0);
        check("scoreboard_empty", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
